// File: rtl/mac_array_ctrl_pkg.sv
// mac_array_ctrl_pkg -- shared definitions for the ternary MAC array controller.
//   state_e            : controller FSM states
//   W_CODE_*           : 2-bit ternary weight lane codes (11 is illegal)
//   SETTLE_MIN/MAX     : legal range of the analog settling wait
//   SETTLE_CNT_W       : width of the settle countdown
//   unit_w()           : select width for a given number of MAC units
package mac_array_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_OUT    = 3'd4
  } state_e;

  localparam logic [1:0] W_CODE_ZERO = 2'b00;
  localparam logic [1:0] W_CODE_POS  = 2'b01;
  localparam logic [1:0] W_CODE_NEG  = 2'b10;
  localparam logic [1:0] W_CODE_BAD  = 2'b11;

  localparam int SETTLE_MIN   = 1;
  localparam int SETTLE_MAX   = 15;
  localparam int SETTLE_CNT_W = 4;

  // A single-unit array still needs a 1-bit select port.
  function automatic int unit_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_settle_timer.sv
// mac_settle_timer -- loadable down-counter that times the analog settling wait.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear_i      : drop any count in progress (run aborted)
//   load_i       : start a new wait of load_val_i cycles
//   load_val_i   : wait length, must be >= 1
//   expire_o     : high during the last cycle of the wait
module mac_settle_timer
  import mac_array_ctrl_pkg::*;
#(
  parameter int CNT_W = SETTLE_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, then load, then count down to zero and park.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A load of L gives L cycles with cnt_q = L..1; the one at 1 is the last.
  assign expire_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl -- sequences weight writes and input vectors into a ternary
// analog MAC array, waits for it to settle, samples and hands back results.
//   cfg_valid/cfg_ready, cfg_unit, cfg_weights : weight write (IDLE only)
//   start, num_vectors, abort                  : run control
//   in_valid/in_ready, in_data                 : input vectors
//   mac_we, mac_unit_sel, mac_wdata            : weight write to array
//   mac_in, mac_in_en, mac_sample, mac_result  : vector drive / sample
//   out_valid/out_ready, out_data              : results
//   busy, done, err_weight                     : status
// Optional: define MAC_ARRAY_CTRL_PERF_EN to add perf_cycles / perf_stall.
module mac_array_ctrl
  import mac_array_ctrl_pkg::*;
#(
  parameter int N             = 32,
  parameter int NUM_UNITS     = 16,
  parameter int DATA_W        = 8,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [unit_w(NUM_UNITS)-1:0]  cfg_unit,
  input  logic [2*N-1:0]                cfg_weights,
  input  logic                          start,
  input  logic                          abort,
  input  logic [15:0]                   num_vectors,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N*DATA_W-1:0]           in_data,
  output logic                          mac_we,
  output logic [unit_w(NUM_UNITS)-1:0]  mac_unit_sel,
  output logic [2*N-1:0]                mac_wdata,
  output logic [N*DATA_W-1:0]           mac_in,
  output logic                          mac_in_en,
  output logic                          mac_sample,
  input  logic [NUM_UNITS*DATA_W-1:0]   mac_result,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_UNITS*DATA_W-1:0]   out_data,
  output logic                          busy,
  output logic                          done,
  output logic                          err_weight
`ifdef MAC_ARRAY_CTRL_PERF_EN
  ,
  output logic [31:0]                   perf_cycles,
  output logic [31:0]                   perf_stall
`endif
);

  localparam int UW = unit_w(NUM_UNITS);
  // Out-of-range settle requests are pulled into the legal window.
  localparam int SETTLE_CLAMP = (SETTLE_CYCLES < SETTLE_MIN) ? SETTLE_MIN :
                                (SETTLE_CYCLES > SETTLE_MAX) ? SETTLE_MAX : SETTLE_CYCLES;
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_CLAMP);

  // True when any lane carries the unused 11 code.
  function automatic logic weights_illegal(input logic [2*N-1:0] w);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < N; i++) begin
      bad = bad | (w[2*i +: 2] == W_CODE_BAD);
    end
    return bad;
  endfunction

  state_e                        state_q, state_d;
  logic [15:0]                   rem_q, rem_d;
  logic                          done_q, done_d;
  logic                          err_q;
  logic                          mac_we_q;
  logic [UW-1:0]                 mac_sel_q;
  logic [2*N-1:0]                mac_wdata_q;
  logic [N*DATA_W-1:0]           mac_in_q;
  logic                          mac_in_en_q;
  logic [NUM_UNITS*DATA_W-1:0]   out_data_q;

  logic cfg_hs_s, cfg_bad_s, start_acc_s, in_hs_s, out_hs_s;
  logic timer_load_s, timer_expire_s;

  // Abort outranks every handshake; a cfg write outranks start.
  assign cfg_hs_s    = cfg_valid & (state_q == ST_IDLE) & ~abort;
  assign cfg_bad_s   = weights_illegal(cfg_weights);
  assign start_acc_s = start & (state_q == ST_IDLE) & ~cfg_valid & ~abort;
  assign in_hs_s     = in_valid & (state_q == ST_RUN) & ~abort;
  assign out_hs_s    = out_ready & (state_q == ST_OUT) & ~abort;

  mac_settle_timer #(
    .CNT_W (SETTLE_CNT_W)
  ) u_settle_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_i    (abort),
    .load_i     (timer_load_s),
    .load_val_i (SETTLE_LOAD),
    .expire_o   (timer_expire_s)
  );

  // Next-state, remaining-count and done pulse.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    done_d       = 1'b0;
    timer_load_s = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      rem_d   = 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_acc_s) begin
            if (num_vectors != 16'd0) begin
              state_d = ST_RUN;
              rem_d   = num_vectors;
            end else begin
              done_d  = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (in_hs_s) begin
            state_d      = ST_SETTLE;
            timer_load_s = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_SETTLE: begin
          if (timer_expire_s) begin
            state_d = ST_SAMPLE;
          end else begin
            state_d = ST_SETTLE;
          end
        end
        ST_SAMPLE: begin
          state_d = ST_OUT;
        end
        ST_OUT: begin
          if (out_hs_s) begin
            rem_d = rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            state_d = ST_OUT;
          end
        end
        default: begin
          state_d = ST_IDLE;
          rem_d   = 16'd0;
        end
      endcase
    end
  end

  // Control state, strobes and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rem_q       <= 16'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mac_we_q    <= 1'b0;
      mac_sel_q   <= {UW{1'b0}};
      mac_wdata_q <= {(2*N){1'b0}};
      mac_in_q    <= {(N*DATA_W){1'b0}};
      mac_in_en_q <= 1'b0;
      out_data_q  <= {(NUM_UNITS*DATA_W){1'b0}};
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      done_q      <= done_d;
      mac_we_q    <= cfg_hs_s & ~cfg_bad_s;
      mac_in_en_q <= in_hs_s;
      if (cfg_hs_s) begin
        mac_sel_q   <= cfg_unit;
        mac_wdata_q <= cfg_weights;
      end
      if (start_acc_s) begin
        err_q <= 1'b0;
      end else if (cfg_hs_s && cfg_bad_s) begin
        err_q <= 1'b1;
      end
      if (in_hs_s) begin
        mac_in_q <= in_data;
      end
      // The edge closing the SAMPLE cycle captures the array outputs.
      if ((state_q == ST_SAMPLE) && !abort) begin
        out_data_q <= mac_result;
      end
    end
  end

`ifdef MAC_ARRAY_CTRL_PERF_EN
  logic [31:0] perf_cycles_q, perf_stall_q;

  // Busy-cycle and output-stall counters, restarted by each accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_cycles_q <= 32'd0;
      perf_stall_q  <= 32'd0;
    end else if (start_acc_s) begin
      perf_cycles_q <= 32'd0;
      perf_stall_q  <= 32'd0;
    end else begin
      if (state_q != ST_IDLE) begin
        perf_cycles_q <= perf_cycles_q + 32'd1;
      end
      if ((state_q == ST_OUT) && !out_ready) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;
`endif

  assign cfg_ready    = (state_q == ST_IDLE);
  assign in_ready     = (state_q == ST_RUN);
  assign mac_sample   = (state_q == ST_SAMPLE);
  assign out_valid    = (state_q == ST_OUT);
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign err_weight   = err_q;
  assign mac_we       = mac_we_q;
  assign mac_unit_sel = mac_sel_q;
  assign mac_wdata    = mac_wdata_q;
  assign mac_in       = mac_in_q;
  assign mac_in_en    = mac_in_en_q;
  assign out_data     = out_data_q;

endmodule

// File: tb/tb_mac_array_ctrl.sv
module tb_mac_array_ctrl;
  import mac_array_ctrl_pkg::*;

  localparam int N  = 32;
  localparam int NU = 16;
  localparam int DW = 8;
  localparam int S  = 3;
  localparam int UW = unit_w(NU);

  logic                clk, reset_n;
  logic                cfg_valid, cfg_ready;
  logic [UW-1:0]       cfg_unit;
  logic [2*N-1:0]      cfg_weights;
  logic                start, abort;
  logic [15:0]         num_vectors;
  logic                in_valid, in_ready;
  logic [N*DW-1:0]     in_data;
  logic                mac_we;
  logic [UW-1:0]       mac_unit_sel;
  logic [2*N-1:0]      mac_wdata;
  logic [N*DW-1:0]     mac_in;
  logic                mac_in_en, mac_sample;
  logic [NU*DW-1:0]    mac_result;
  logic                out_valid, out_ready;
  logic [NU*DW-1:0]    out_data;
  logic                busy, done, err_weight;
`ifdef MAC_ARRAY_CTRL_PERF_EN
  logic [31:0]         perf_cycles, perf_stall;
`endif

  mac_array_ctrl #(.N(N), .NUM_UNITS(NU), .DATA_W(DW), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_unit(cfg_unit), .cfg_weights(cfg_weights),
    .start(start), .abort(abort), .num_vectors(num_vectors),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mac_we(mac_we), .mac_unit_sel(mac_unit_sel), .mac_wdata(mac_wdata),
    .mac_in(mac_in), .mac_in_en(mac_in_en), .mac_sample(mac_sample), .mac_result(mac_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .err_weight(err_weight)
`ifdef MAC_ARRAY_CTRL_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: a run is "idle or not", a count of vectors left, and the
  // age (cycles since acceptance) of the vector in flight, -1 when none.
  bit              m_idle, m_err, m_done, m_we, m_in_en;
  int              m_left, m_age;
  logic [UW-1:0]   m_sel;
  logic [2*N-1:0]  m_wdata;
  logic [N*DW-1:0] m_in;
  logic [NU*DW-1:0] m_out;
  int unsigned     m_pc, m_ps;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit has_bad_lane(input logic [2*N-1:0] w);
    bit b = 0;
    for (int i = 0; i < N; i++) if (w[2*i +: 2] == 2'b11) b = 1;
    return b;
  endfunction

  task automatic model_reset();
    m_idle = 1; m_err = 0; m_done = 0; m_we = 0; m_in_en = 0;
    m_left = 0; m_age = -1; m_sel = '0; m_wdata = '0; m_in = '0; m_out = '0;
    m_pc = 0; m_ps = 0;
  endtask

  // What one rising edge does, given the inputs currently driven.
  task automatic model_edge();
    m_we = 0; m_in_en = 0; m_done = 0;
    if (!m_idle) m_pc++;
    if (m_age == S + 1 && !out_ready) m_ps++;
    if (abort) begin
      m_idle = 1; m_left = 0; m_age = -1;
    end else if (m_idle) begin
      if (cfg_valid) begin
        m_sel = cfg_unit; m_wdata = cfg_weights;
        if (has_bad_lane(cfg_weights)) m_err = 1; else m_we = 1;
      end else if (start) begin
        m_err = 0; m_pc = 0; m_ps = 0;
        if (num_vectors == 0) m_done = 1;
        else begin m_idle = 0; m_left = num_vectors; end
      end
    end else if (m_age < 0) begin
      if (in_valid) begin m_in = in_data; m_in_en = 1; m_age = 0; end
    end else if (m_age <= S) begin
      if (m_age == S) m_out = mac_result;
      m_age++;
    end else if (out_ready) begin
      m_left--; m_age = -1;
      if (m_left == 0) begin m_idle = 1; m_done = 1; end
    end
  endtask

  task automatic compare_all();
    chk("cfg_ready", cfg_ready, m_idle);
    chk("busy", busy, !m_idle);
    chk("in_ready", in_ready, !m_idle && m_age < 0);
    chk("mac_sample", mac_sample, m_age == S);
    chk("out_valid", out_valid, m_age == S + 1);
    chk("done", done, m_done);
    chk("err_weight", err_weight, m_err);
    chk("mac_we", mac_we, m_we);
    chk("mac_unit_sel", mac_unit_sel, m_sel);
    chk("mac_wdata", mac_wdata, m_wdata);
    chk("mac_in", mac_in, m_in);
    chk("mac_in_en", mac_in_en, m_in_en);
    if (m_age == S + 1) chk("out_data", out_data, m_out);
`ifdef MAC_ARRAY_CTRL_PERF_EN
    chk("perf_cycles", perf_cycles, m_pc);
    chk("perf_stall", perf_stall, m_ps);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    cfg_valid = 0; start = 0; abort = 0; in_valid = 0; out_ready = 0;
    cfg_unit = '0; cfg_weights = '0; num_vectors = 16'd0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N * DW / 32; i++) in_data[32*i +: 32] = $urandom();
    for (int i = 0; i < NU * DW / 32; i++) mac_result[32*i +: 32] = $urandom();
  endtask

  task automatic wait_out_valid(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 20) begin step(); cycles++; end
  endtask

  int lat;
  logic [NU*DW-1:0] held;

  initial begin
    reset_n = 0; idle_inputs(); in_data = '0; mac_result = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_data", out_data, 0);
    compare_all();
    reset_n = 1;

    // Write unit 5, every lane +1.
    cfg_valid = 1; cfg_unit = UW'(5); cfg_weights = {N{2'b01}};
    step();
    cfg_valid = 0;
    chk("we_pulse", mac_we, 1'b1);
    chk("we_sel", mac_unit_sel, 5);
    chk("we_wdata", mac_wdata, 64'h5555_5555_5555_5555);
    step();
    chk("we_one_cycle", mac_we, 1'b0);

    // Lane 0 illegal: handshake completes, no strobe, sticky error.
    cfg_valid = 1; cfg_unit = UW'(2); cfg_weights = {{(N-1){2'b10}}, 2'b11};
    step();
    cfg_valid = 0;
    chk("bad_no_we", mac_we, 1'b0);
    chk("bad_err", err_weight, 1'b1);
    step(); step();
    chk("bad_err_sticky", err_weight, 1'b1);

    // Three-vector run, output always accepted.
    start = 1; num_vectors = 16'd3; out_ready = 1;
    step();
    start = 0;
    chk("start_clears_err", err_weight, 1'b0);
    chk("run_busy", busy, 1'b1);
    for (int v = 0; v < 3; v++) begin
      rand_data(); in_valid = 1;
      step(); in_valid = 0; lat = 1;
      while (!out_valid && lat < 20) begin step(); lat++; end
      chk("latency", lat, S + 2);
      step();
      chk("done_after_result", done, v == 2);
    end
    chk("idle_after_run", busy, 1'b0);

    // Output held off for four cycles.
    start = 1; num_vectors = 16'd1; out_ready = 0;
    step(); start = 0;
    rand_data(); in_valid = 1; step(); in_valid = 0;
    wait_out_valid(lat);
    chk("stall_reached_out", out_valid, 1'b1);
    held = out_data;
    for (int k = 0; k < 4; k++) begin
      mac_result = ~mac_result;
      step();
      chk("stall_data_stable", out_data, held);
      chk("stall_in_ready", in_ready, 1'b0);
    end
`ifdef MAC_ARRAY_CTRL_PERF_EN
    chk("stall_count4", perf_stall, 32'd4);
`endif
    out_ready = 1; step(); out_ready = 0;
    chk("stall_done", done, 1'b1);

    // Abort while settling.
    start = 1; num_vectors = 16'd2; step(); start = 0;
    rand_data(); in_valid = 1; step(); in_valid = 0;
    abort = 1; step(); abort = 0;
    chk("abort_idle", busy, 1'b0);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_no_done", done, 1'b0);
    step();
    chk("abort_no_done_later", done, 1'b0);

    // Reset while presenting a result.
    start = 1; num_vectors = 16'd2; step(); start = 0;
    rand_data(); in_valid = 1; step(); in_valid = 0;
    wait_out_valid(lat);
    chk("rst_reached_out", out_valid, 1'b1);
    reset_n = 0;
    #1;
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_out_data", out_data, 0);
    chk("rst_mid_mac_in", mac_in, 0);
    chk("rst_mid_cfg_ready", cfg_ready, 1'b1);
    model_reset();
    compare_all();
    #1 reset_n = 1;
    step();
    chk("rst_release_cfg_ready", cfg_ready, 1'b1);
    chk("rst_release_done", done, 1'b0);

    // Random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_unit  = UW'($urandom_range(0, NU - 1));
      for (int i = 0; i < N; i++) cfg_weights[2*i +: 2] = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) cfg_weights[2*$urandom_range(0, N-1) +: 2] = 2'b11;
      start       = ($urandom_range(0, 5) == 0);
      num_vectors = 16'($urandom_range(0, 4));
      abort       = ($urandom_range(0, 59) == 0);
      in_valid    = 1'($urandom_range(0, 1));
      out_ready   = ($urandom_range(0, 3) != 0);
      rand_data();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
